// File: rtl/peripheral_mpi_wishbone.sv
// Wishbone-slave message buffer between a CPU tile and a flit-based NoC.
// Software pushes TX flits and pops RX flits; whole packets go out on the NoC.
module peripheral_mpi_wishbone #(
  parameter int NOC_FLIT_WIDTH = 32,
  parameter int SIZE           = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic [NOC_FLIT_WIDTH-1:0] noc_out_flit,
  output logic                      noc_out_last,
  output logic                      noc_out_valid,
  input  logic                      noc_out_ready,
  input  logic [NOC_FLIT_WIDTH-1:0] noc_in_flit,
  input  logic                      noc_in_last,
  input  logic                      noc_in_valid,
  output logic                      noc_in_ready,
  input  logic [31:0]               wb_adr_i,
  input  logic                      wb_we_i,
  input  logic                      wb_cyc_i,
  input  logic                      wb_stb_i,
  input  logic [31:0]               wb_dat_i,
  output logic [31:0]               wb_dat_o,
  output logic                      wb_ack_o,
  output logic                      wb_err_o,
  output logic                      irq
);

  localparam int AW = (SIZE > 2) ? $clog2(SIZE) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] SIZE_C = CW'(SIZE);

  // Each FIFO entry stores {last, flit}.
  logic [NOC_FLIT_WIDTH:0] tx_mem [SIZE];
  logic [NOC_FLIT_WIDTH:0] rx_mem [SIZE];

  logic [AW-1:0] tx_wr_ptr_reg, tx_rd_ptr_reg;
  logic [AW-1:0] rx_wr_ptr_reg, rx_rd_ptr_reg;
  logic [CW-1:0] tx_count_reg, rx_count_reg;
  logic [CW-1:0] tx_pkt_cnt_reg, rx_pkt_cnt_reg;
  logic          irq_en_reg;
  logic          irq_reg;
  logic          ack_reg, err_reg;
  logic [31:0]   dat_reg;

  logic          req;
  logic [2:0]    adr;
  logic          tx_full, rx_empty, rx_full;
  logic [NOC_FLIT_WIDTH:0] tx_head, rx_head;
  logic          tx_head_last, rx_head_last;
  logic          tx_push, tx_push_last, tx_pop;
  logic          rx_push, rx_pop;
  logic          ctrl_wr;
  logic          acc_ack, acc_err;
  logic [31:0]   rd_data;
  logic [31:0]   status;
  logic [CW-1:0] tx_free;
  logic [7:0]    tx_free8, rx_occ8;

  assign tx_full      = (tx_count_reg == SIZE_C);
  assign rx_full      = (rx_count_reg == SIZE_C);
  assign rx_empty     = (rx_count_reg == '0);
  assign tx_head      = tx_mem[tx_rd_ptr_reg];
  assign rx_head      = rx_mem[rx_rd_ptr_reg];
  assign tx_head_last = tx_head[NOC_FLIT_WIDTH];
  assign rx_head_last = ~rx_empty & rx_head[NOC_FLIT_WIDTH];

  // Only complete packets are offered, so a partial packet waits in the FIFO.
  assign noc_out_valid = (tx_pkt_cnt_reg != '0);
  assign noc_out_flit  = noc_out_valid ? tx_head[NOC_FLIT_WIDTH-1:0] : '0;
  assign noc_out_last  = noc_out_valid & tx_head_last;
  assign tx_pop        = noc_out_valid & noc_out_ready;

  assign noc_in_ready  = ~rx_full;
  assign rx_push       = noc_in_valid & noc_in_ready;

  assign tx_free  = SIZE_C - tx_count_reg;
  assign tx_free8 = 8'(tx_free);
  assign rx_occ8  = 8'(rx_count_reg);
  assign status   = {8'h00, rx_occ8, tx_free8, 4'h0,
                     irq_en_reg, tx_full, rx_head_last, ~rx_empty};

  assign req = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
  assign adr = wb_adr_i[4:2];

  always_comb begin
    acc_ack      = 1'b0;
    acc_err      = 1'b0;
    rd_data      = '0;
    tx_push      = 1'b0;
    tx_push_last = 1'b0;
    rx_pop       = 1'b0;
    ctrl_wr      = 1'b0;
    if (req) begin
      case (adr)
        3'd0, 3'd1: begin
          if (wb_we_i && !tx_full) begin
            acc_ack      = 1'b1;
            tx_push      = 1'b1;
            tx_push_last = adr[0];
          end else begin
            acc_err = 1'b1;
          end
        end
        3'd2: begin
          if (!wb_we_i && !rx_empty) begin
            acc_ack = 1'b1;
            rx_pop  = 1'b1;
            rd_data = 32'(rx_head[NOC_FLIT_WIDTH-1:0]);
          end else begin
            acc_err = 1'b1;
          end
        end
        3'd3: begin
          if (!wb_we_i) begin
            acc_ack = 1'b1;
            rd_data = status;
          end else begin
            acc_err = 1'b1;
          end
        end
        3'd4: begin
          acc_ack = 1'b1;
          if (wb_we_i) begin
            ctrl_wr = 1'b1;
          end else begin
            rd_data = {31'h0, irq_en_reg};
          end
        end
        default: acc_err = 1'b1;
      endcase
    end
  end

  // Storage arrays carry no reset; pointers and counts define validity.
  always_ff @(posedge clk) begin
    if (tx_push) begin
      tx_mem[tx_wr_ptr_reg] <= {tx_push_last, NOC_FLIT_WIDTH'(wb_dat_i)};
    end
    if (rx_push) begin
      rx_mem[rx_wr_ptr_reg] <= {noc_in_last, noc_in_flit};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_wr_ptr_reg <= '0;
      tx_rd_ptr_reg <= '0;
      tx_count_reg  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr_reg <= tx_wr_ptr_reg + 1'b1;
      if (tx_pop)  tx_rd_ptr_reg <= tx_rd_ptr_reg + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_count_reg <= tx_count_reg + 1'b1;
        2'b01:   tx_count_reg <= tx_count_reg - 1'b1;
        default: tx_count_reg <= tx_count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_wr_ptr_reg <= '0;
      rx_rd_ptr_reg <= '0;
      rx_count_reg  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr_reg <= rx_wr_ptr_reg + 1'b1;
      if (rx_pop)  rx_rd_ptr_reg <= rx_rd_ptr_reg + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_count_reg <= rx_count_reg + 1'b1;
        2'b01:   rx_count_reg <= rx_count_reg - 1'b1;
        default: rx_count_reg <= rx_count_reg;
      endcase
    end
  end

  // Packet counters: simultaneous increment and decrement cancel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_pkt_cnt_reg <= '0;
      rx_pkt_cnt_reg <= '0;
    end else begin
      case ({tx_push & tx_push_last, tx_pop & tx_head_last})
        2'b10:   tx_pkt_cnt_reg <= tx_pkt_cnt_reg + 1'b1;
        2'b01:   tx_pkt_cnt_reg <= tx_pkt_cnt_reg - 1'b1;
        default: tx_pkt_cnt_reg <= tx_pkt_cnt_reg;
      endcase
      case ({rx_push & noc_in_last, rx_pop & rx_head_last})
        2'b10:   rx_pkt_cnt_reg <= rx_pkt_cnt_reg + 1'b1;
        2'b01:   rx_pkt_cnt_reg <= rx_pkt_cnt_reg - 1'b1;
        default: rx_pkt_cnt_reg <= rx_pkt_cnt_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_en_reg <= 1'b0;
      irq_reg    <= 1'b0;
      ack_reg    <= 1'b0;
      err_reg    <= 1'b0;
      dat_reg    <= '0;
    end else begin
      if (ctrl_wr) irq_en_reg <= wb_dat_i[0];
      irq_reg <= irq_en_reg & (rx_pkt_cnt_reg != '0);
      ack_reg <= acc_ack;
      err_reg <= acc_err;
      dat_reg <= acc_ack ? rd_data : 32'h0;
    end
  end

  assign wb_ack_o = ack_reg;
  assign wb_err_o = err_reg;
  assign wb_dat_o = dat_reg;
  assign irq      = irq_reg;

endmodule

// File: tb/tb_peripheral_mpi_wishbone.sv
// Scoreboard bench for peripheral_mpi_wishbone: bus and NoC responses are
// queued at stimulus time and checked by independent monitors.
module tb_peripheral_mpi_wishbone;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] noc_out_flit;
  logic        noc_out_last;
  logic        noc_out_valid;
  logic        noc_out_ready;
  logic [31:0] noc_in_flit;
  logic        noc_in_last;
  logic        noc_in_valid;
  logic        noc_in_ready;
  logic [31:0] wb_adr_i;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;
  logic        irq;

  peripheral_mpi_wishbone #(.NOC_FLIT_WIDTH(32), .SIZE(16)) dut (
    .clk(clk), .rst(rst),
    .noc_out_flit(noc_out_flit), .noc_out_last(noc_out_last),
    .noc_out_valid(noc_out_valid), .noc_out_ready(noc_out_ready),
    .noc_in_flit(noc_in_flit), .noc_in_last(noc_in_last),
    .noc_in_valid(noc_in_valid), .noc_in_ready(noc_in_ready),
    .wb_adr_i(wb_adr_i), .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i),
    .wb_stb_i(wb_stb_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        err;
    logic        chk;
    logic [31:0] dat;
  } bus_exp_t;

  bus_exp_t    bus_q [$];
  logic [32:0] noc_q [$];
  bus_exp_t    mon_e;
  logic [32:0] mon_n;
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  // Bus monitor
  always @(negedge clk) begin
    if (rst && (wb_ack_o || wb_err_o)) begin
      if (bus_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL bus_unexpected: ack=%0b err=%0b dat=0x%08h, none expected",
                 wb_ack_o, wb_err_o, wb_dat_o);
      end else begin
        mon_e = bus_q.pop_front();
        check("bus_err", {31'h0, wb_err_o}, {31'h0, mon_e.err});
        if (mon_e.chk) check("bus_dat", wb_dat_o, mon_e.dat);
      end
    end
  end

  // NoC output monitor
  always @(negedge clk) begin
    if (rst && noc_out_valid && noc_out_ready) begin
      if (noc_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL noc_unexpected: flit=0x%08h last=%0b, none expected",
                 noc_out_flit, noc_out_last);
      end else begin
        mon_n = noc_q.pop_front();
        check("noc_flit", noc_out_flit, mon_n[31:0]);
        check("noc_last", {31'h0, noc_out_last}, {31'h0, mon_n[32]});
      end
    end
  end

  task automatic wb(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                    input logic e_err, input logic e_chk, input logic [31:0] e_dat);
    bus_q.push_back({e_err, e_chk, e_dat});
    @(posedge clk); #1;
    wb_adr_i = adr; wb_we_i = we; wb_dat_i = dat;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    @(posedge clk); #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    check("wb_resp_present", {31'h0, wb_ack_o | wb_err_o}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    noc_out_ready = 1'b0;
    noc_in_flit = '0; noc_in_last = 1'b0; noc_in_valid = 1'b0;
    wb_adr_i = '0; wb_we_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_dat_i = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    check("rst_ack", {31'h0, wb_ack_o}, 32'h0);
    check("rst_err", {31'h0, wb_err_o}, 32'h0);
    check("rst_dat", wb_dat_o, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    check("rst_out_valid", {31'h0, noc_out_valid}, 32'h0);
    check("rst_out_flit", noc_out_flit, 32'h0);
    check("rst_in_ready", {31'h0, noc_in_ready}, 32'h1);

    wb(32'h0C, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_1000);

    // Packet only leaves once its last flit is written
    noc_out_ready = 1'b1;
    noc_q.push_back({1'b0, 32'h1111_1111});
    noc_q.push_back({1'b1, 32'h2222_2222});
    wb(32'h00, 1'b1, 32'h1111_1111, 1'b0, 1'b0, 32'h0);
    check("tx_wait_last", {31'h0, noc_out_valid}, 32'h0);
    wb(32'h04, 1'b1, 32'h2222_2222, 1'b0, 1'b0, 32'h0);
    check("tx_valid_1", {31'h0, noc_out_valid}, 32'h1);
    @(posedge clk); #1;
    check("tx_valid_2", {31'h0, noc_out_valid}, 32'h1);
    @(posedge clk); #1;
    check("tx_drained", {31'h0, noc_out_valid}, 32'h0);

    // RX packet and interrupt
    wb(32'h10, 1'b1, 32'h1, 1'b0, 1'b0, 32'h0);
    wb(32'h10, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1);
    noc_in_valid = 1'b1; noc_in_flit = 32'hA; noc_in_last = 1'b0;
    @(posedge clk); #1;
    noc_in_flit = 32'hB; noc_in_last = 1'b1;
    @(posedge clk); #1;
    noc_in_valid = 1'b0; noc_in_last = 1'b0;
    check("irq_lag", {31'h0, irq}, 32'h0);
    @(posedge clk); #1;
    check("irq_rise", {31'h0, irq}, 32'h1);
    wb(32'h0C, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0002_1009);
    wb(32'h08, 1'b0, 32'h0, 1'b0, 1'b1, 32'hA);
    wb(32'h08, 1'b0, 32'h0, 1'b0, 1'b1, 32'hB);
    check("irq_hold", {31'h0, irq}, 32'h1);
    @(posedge clk); #1;
    check("irq_fall", {31'h0, irq}, 32'h0);

    // Error accesses
    wb(32'h08, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0);
    wb(32'h0C, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_1008);
    wb(32'h14, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0);
    wb(32'h0C, 1'b1, 32'h5, 1'b1, 1'b1, 32'h0);
    wb(32'h00, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0);

    // Fill TX while NoC stalls
    noc_out_ready = 1'b0;
    for (int i = 0; i < 16; i++) wb(32'h00, 1'b1, 32'h300 + i, 1'b0, 1'b0, 32'h0);
    wb(32'h00, 1'b1, 32'hDEAD, 1'b1, 1'b1, 32'h0);
    wb(32'h0C, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_000C);
    check("tx_full_no_valid", {31'h0, noc_out_valid}, 32'h0);

    // Fill RX from the NoC
    noc_in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      noc_in_flit = 32'h100 + i;
      check("rx_ready_pre", {31'h0, noc_in_ready}, 32'h1);
      @(posedge clk); #1;
    end
    noc_in_flit = 32'h110;
    check("rx_ready_full", {31'h0, noc_in_ready}, 32'h0);
    @(posedge clk); #1;
    check("rx_ready_held", {31'h0, noc_in_ready}, 32'h0);
    noc_in_valid = 1'b0;
    wb(32'h0C, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0010_000D);
    wb(32'h08, 1'b0, 32'h0, 1'b0, 1'b1, 32'h100);
    check("rx_ready_reraise", {31'h0, noc_in_ready}, 32'h1);

    // Reset mid-stream discards everything
    noc_in_valid = 1'b1; noc_in_flit = 32'h200;
    @(posedge clk); #2;
    rst = 1'b0; noc_in_valid = 1'b0;
    #2;
    check("rst_mid_irq", {31'h0, irq}, 32'h0);
    @(posedge clk); #1 rst = 1'b1;
    check("rst_mid_in_ready", {31'h0, noc_in_ready}, 32'h1);
    wb(32'h0C, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_1000);
    wb(32'h08, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0);
    noc_out_ready = 1'b1;
    noc_q.push_back({1'b1, 32'h33});
    wb(32'h04, 1'b1, 32'h33, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    check("post_rst_drained", {31'h0, noc_out_valid}, 32'h0);
    @(posedge clk); #1;

    check("bus_q_empty", bus_q.size(), 32'h0);
    check("noc_q_empty", noc_q.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/peripheral_mpi_wishbone.md
Name: peripheral_mpi_wishbone

Overview:
- Wishbone-slave message-passing buffer connecting a CPU tile to a flit-based NoC.
- Software writes flits into a TX FIFO; complete packets are streamed out on the NoC.
- Flits arriving from the NoC are stored in an RX FIFO and popped by software reads.
- An interrupt is raised when a complete packet is waiting.

Parameters:
NOC_FLIT_WIDTH, 32, flit width in bits; only 32 is supported (matches Wishbone data width).
SIZE, 16, depth in flits of each FIFO; power of two, 2..128.

Ports:
clk  in  1  single clock
rst  in  1  asynchronous, active-low reset
noc_out_flit  out  NOC_FLIT_WIDTH  outgoing flit
noc_out_last  out  1  outgoing flit is the last of its packet
noc_out_valid  out  1  outgoing flit valid
noc_out_ready  in  1  NoC accepts outgoing flit
noc_in_flit  in  NOC_FLIT_WIDTH  incoming flit
noc_in_last  in  1  incoming flit is the last of its packet
noc_in_valid  in  1  incoming flit valid
noc_in_ready  out  1  block accepts incoming flit
wb_adr_i  in  32  byte address; only bits [4:2] are decoded
wb_we_i  in  1  write enable
wb_cyc_i  in  1  bus cycle
wb_stb_i  in  1  strobe
wb_dat_i  in  32  write data
wb_dat_o  out  32  read data
wb_ack_o  out  1  access acknowledge
wb_err_o  out  1  access error
irq  out  1  interrupt, level, active-high

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst).
- Reset values: both FIFOs empty, packet counters 0, irq_en 0. All outputs 0: wb_ack_o, wb_err_o, wb_dat_o, irq, noc_out_valid, noc_out_last, noc_out_flit. noc_in_ready is 1 once reset releases.
- Reset mid-operation discards all buffered flits.
- Bus request: req = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o.
- On a request cycle, exactly one of ack or err is registered and is high the next cycle for exactly one cycle. wb_dat_o is valid in that same cycle.
- Back-to-back accesses therefore take 2 cycles each.
- Side effects (push, pop, register write) happen on the request clock edge and only if the access is acked.
- Register map (by wb_adr_i[4:2]):
  - 0x00 TX_DATA, write: push wb_dat_i with last=0.
  - 0x04 TX_LAST, write: push wb_dat_i with last=1 and increment tx_pkt_cnt.
  - 0x08 RX_DATA, read: return the RX head flit and pop it. If the popped flit has last=1, decrement rx_pkt_cnt.
  - 0x0C STATUS, read:
    - bit0 rx_not_empty
    - bit1 rx_head_last
    - bit2 tx_full
    - bit3 irq_en
    - bits[15:8] tx free slots
    - bits[23:16] rx occupancy
    - other bits 0
  - 0x10 CTRL, read/write: bit0 irq_en; other bits read 0.
- Error conditions (err instead of ack, no side effect):
  - write to 0x00 or 0x04 while TX is full
  - read of 0x08 while RX is empty
  - read of 0x00 or 0x04
  - write of 0x08 or 0x0C
  - addresses 0x14..0x1C
- On err, wb_dat_o = 0.
- TX output:
  - noc_out_valid = tx_pkt_cnt != 0; flit and last are taken from the TX head.
  - Pop on valid & ready; popping a flit with last=1 decrements tx_pkt_cnt.
  - A packet never leaves before its last flit has been written.
- RX input:
  - noc_in_ready = RX not full.
  - Push on valid & ready; pushing a flit with last=1 increments rx_pkt_cnt.
- irq = irq_en & (rx_pkt_cnt != 0), registered, one cycle behind the state.
- Simultaneous events:
  - A push and pop on the same FIFO in one cycle are both performed; occupancy is unchanged.
  - Counter increment and decrement in one cycle cancel.
  - Pointers wrap modulo SIZE. Occupancy counters are log2(SIZE)+1 bits and reach exactly SIZE when full.
- Flits are only accepted via valid & ready; no overflow is possible.

Test Plan:
- Release reset, then read 0x0C -> ack after 1 cycle with data 0x00001000 (SIZE=16: tx free = 16); irq=0, noc_out_valid=0.
- Write 0x11111111 to 0x00, then 0x22222222 to 0x04, with noc_out_ready=1:
  - noc_out_valid stays 0 until the second write completes;
  - then flits 0x11111111 (last=0) and 0x22222222 (last=1) appear on consecutive cycles.
- Write 1 to 0x10, then drive NoC flits 0xA (last=0) and 0xB (last=1):
  - irq rises after 0xB is accepted;
  - reading 0x08 twice returns 0xA then 0xB;
  - irq falls after the second pop.
- Read 0x08 with RX empty -> wb_err_o pulse with wb_dat_o=0; status unchanged.
- Keep noc_out_ready=0 and write 17 flits to 0x00:
  - writes 1..16 ack, write 17 errs;
  - STATUS reads tx_full=1, tx free=0.
- Hold noc_in_valid with 16 flits -> noc_in_ready drops to 0 after the 16th is accepted. One RX_DATA read re-raises noc_in_ready the next cycle. A reset asserted mid-stream clears all occupancy to 0.
